tx_fifo_param: RTL and testbench

Parametrised synchronous FIFO. Successor to the fixed 4x8 TX buffer in the I2C slave datapath. Adds:
- configurable width and depth
- same-cycle read and write
- occupancy count and almost-full/almost-empty thresholds
- registered read with a valid strobe, synchronous flush, and sticky overflow/underflow flags

Sits between the register-interface write side and the I2C shift-out logic. Used for both TX and RX buffering.

---
 rtl/tx_fifo_param.sv | 67 ++++++
 tb/tb_tx_fifo_param.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tx_fifo_param.sv
// tx_fifo_param: parametrised synchronous FIFO with registered read, flush and sticky error flags
module tx_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0] w_ptr, r_ptr;
  logic wa, ra;
  assign ra = rd_en & ~empty & ~flush;
  assign wa = wr_en & (~full | ra) & ~flush;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign almost_full = count >= (AW+1)'(AFULL_TH);
  assign almost_empty = count <= (AW+1)'(AEMPTY_TH);
  // storage array, written only on an accepted write; never reset
  always_ff @(posedge clk)
    if (wa) mem[w_ptr] <= wr_data;
  // pointers, occupancy and registered read port; flush clears all but rd_data
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
      rd_data <= '0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wa) w_ptr <= w_ptr + AW'(1);
      if (ra) r_ptr <= r_ptr + AW'(1);
      if (ra) rd_data <= mem[r_ptr];
      rd_valid <= ra;
      count <= (wa & ~ra) ? count + (AW+1)'(1) : (ra & ~wa) ? count - (AW+1)'(1) : count;
    end
  // sticky error flags; a new error beats clr_err, flush freezes them
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else if (!flush) begin
      overflow <= (overflow & ~clr_err) | (wr_en & ~wa);
      underflow <= (underflow & ~clr_err) | (rd_en & ~ra);
    end
endmodule

// File: tb/tb_tx_fifo_param.sv
// tb_tx_fifo_param: scoreboard bench for tx_fifo_param at DATA_W=8, DEPTH=16
module tb_tx_fifo_param;
  localparam int W = 8;
  localparam int D = 16;
  logic clk = 0, rst = 1, flush = 0, wr_en = 0, rd_en = 0, clr_err = 0;
  logic [W-1:0] wr_data = '0;
  logic [W-1:0] rd_data;
  logic rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  int total = 0, bad = 0, pulses = 0;
  logic [W-1:0] mq[$];
  logic [W-1:0] exp_q[$];
  tx_fifo_param #(.DATA_W(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .full(full),
    .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
  );
  always #5 clk = ~clk;
  // read-data scoreboard: every rd_valid must match the next expected word
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst && rd_valid) begin
      total++;
      pulses++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected: rd_valid=1 rd_data=%h with no read outstanding", rd_data);
      end else begin
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          bad++;
          $display("FAIL rd_data: got %h want %h", rd_data, e);
        end
      end
    end
  end
  task automatic step(input logic w, input logic [W-1:0] d, input logic r, input logic f, input logic c);
    logic ra, wa;
    wr_en = w; wr_data = d; rd_en = r; flush = f; clr_err = c;
    ra = r && !f && mq.size() > 0;
    wa = w && !f && (mq.size() < D || ra);
    @(posedge clk);
    if (ra) exp_q.push_back(mq.pop_front());
    if (wa) mq.push_back(d);
    if (f) mq.delete();
    #1;
    wr_en = 0; rd_en = 0; flush = 0; clr_err = 0;
  endtask
  task automatic drained(input string name);
    step(0, 0, 0, 0, 0);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_missing_reads: %0d reads never produced rd_valid, want 0", name, exp_q.size());
    end
  endtask
  task automatic test_reset;
    rst = 1;
    #12 rst = 0;
    @(posedge clk); #1;
    total++;
    if ({empty, almost_empty, full, almost_full, rd_valid, overflow, underflow} !== 7'b1100000) begin
      bad++;
      $display("FAIL reset_flags: got %b want 1100000", {empty, almost_empty, full, almost_full, rd_valid, overflow, underflow});
    end
    total++;
    if (count !== 5'd0 || rd_data !== 8'h00) begin
      bad++;
      $display("FAIL reset_values: count=%0d rd_data=%h want 0 00", count, rd_data);
    end
  endtask
  task automatic test_fill;
    for (int i = 1; i <= D; i++) begin
      step(1, W'(i), 0, 0, 0);
      total++;
      if (count !== 5'(i) || almost_full !== (i >= 14) || full !== (i == D) || almost_empty !== (i <= 2)) begin
        bad++;
        $display("FAIL fill_%0d: count=%0d af=%b f=%b ae=%b want %0d %b %b %b", i, count, almost_full, full, almost_empty, i, i >= 14, i == D, i <= 2);
      end
    end
    step(1, 8'hAA, 0, 0, 0);
    total++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      bad++;
      $display("FAIL overflow_17th: ov=%b count=%0d want 1 16", overflow, count);
    end
    pulses = 0;
    for (int i = 0; i < D; i++) begin
      step(0, 0, 1, 0, 0);
      total++;
      if (rd_valid !== 1'b1) begin
        bad++;
        $display("FAIL drain_latency_%0d: rd_valid=%b want 1", i, rd_valid);
      end
    end
    drained("fill");
    total++;
    if (pulses != D || empty !== 1'b1 || count !== 5'd0) begin
      bad++;
      $display("FAIL drain_end: pulses=%0d empty=%b count=%0d want 16 1 0", pulses, empty, count);
    end
    step(0, 0, 0, 0, 1);
    total++;
    if (overflow !== 1'b0) begin
      bad++;
      $display("FAIL clr_overflow: ov=%b want 0", overflow);
    end
  endtask
  task automatic test_wrap;
    for (int i = 0; i < 12; i++) step(1, W'(8'h60 + i), 0, 0, 0);
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0);
    drained("wrap_a");
    for (int i = 0; i < 12; i++) step(1, W'(8'h20 + i), 0, 0, 0);
    total++;
    if (count !== 5'd12) begin
      bad++;
      $display("FAIL wrap_count12: count=%0d want 12", count);
    end
    for (int i = 0; i < 12; i++) step(0, 0, 1, 0, 0);
    drained("wrap_b");
    total++;
    if (count !== 5'd0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL wrap_count0: count=%0d empty=%b want 0 1", count, empty);
    end
  endtask
  task automatic test_full_rw;
    for (int i = 0; i < D; i++) step(1, W'(8'h30 + i), 0, 0, 0);
    step(1, 8'h55, 1, 0, 0);
    total++;
    if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1 || rd_data !== 8'h30) begin
      bad++;
      $display("FAIL full_rw: count=%0d ov=%b full=%b rd_data=%h want 16 0 1 30", count, overflow, full, rd_data);
    end
    for (int i = 0; i < D; i++) step(0, 0, 1, 0, 0);
    total++;
    if (rd_data !== 8'h55) begin
      bad++;
      $display("FAIL full_rw_last: rd_data=%h want 55", rd_data);
    end
    drained("full_rw");
  endtask
  task automatic test_empty_rw;
    step(1, 8'h77, 1, 0, 0);
    total++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || count !== 5'd1) begin
      bad++;
      $display("FAIL empty_rw: un=%b rv=%b count=%0d want 1 0 1", underflow, rd_valid, count);
    end
    step(0, 0, 1, 0, 0);
    total++;
    if (rd_data !== 8'h77 || rd_valid !== 1'b1) begin
      bad++;
      $display("FAIL empty_rw_read: rd_data=%h rv=%b want 77 1", rd_data, rd_valid);
    end
    step(0, 0, 1, 0, 1);
    total++;
    if (underflow !== 1'b1) begin
      bad++;
      $display("FAIL clr_vs_set: un=%b want 1", underflow);
    end
    step(0, 0, 0, 0, 1);
    total++;
    if (underflow !== 1'b0) begin
      bad++;
      $display("FAIL clr_underflow: un=%b want 0", underflow);
    end
    drained("empty_rw");
  endtask
  task automatic test_flush;
    step(0, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) step(1, W'(8'h40 + i), 0, 0, 0);
    step(1, 8'h99, 1, 1, 0);
    total++;
    if (count !== 5'd0 || empty !== 1'b1 || rd_valid !== 1'b0 || rd_data !== 8'h77 || underflow !== 1'b1 || overflow !== 1'b0) begin
      bad++;
      $display("FAIL flush: count=%0d empty=%b rv=%b rd_data=%h un=%b ov=%b want 0 1 0 77 1 0", count, empty, rd_valid, rd_data, underflow, overflow);
    end
    step(0, 0, 1, 0, 0);
    total++;
    if (rd_valid !== 1'b0 || count !== 5'd0) begin
      bad++;
      $display("FAIL flush_nowrite: rv=%b count=%0d want 0 0", rd_valid, count);
    end
    drained("flush");
  endtask
  task automatic test_async_reset;
    for (int i = 0; i < 5; i++) step(1, W'(8'h80 + i), 0, 0, 0);
    total++;
    if (count !== 5'd5) begin
      bad++;
      $display("FAIL pre_reset_count: count=%0d want 5", count);
    end
    #2 rst = 1;
    #1;
    total++;
    if (count !== 5'd0 || empty !== 1'b1 || almost_empty !== 1'b1 || rd_data !== 8'h00 || underflow !== 1'b0 || rd_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: count=%0d empty=%b ae=%b rd_data=%h un=%b rv=%b want 0 1 1 00 0 0", count, empty, almost_empty, rd_data, underflow, rd_valid);
    end
    mq.delete();
    exp_q.delete();
    #10 rst = 0;
  endtask
  initial begin
    test_reset;
    test_fill;
    test_wrap;
    test_full_rw;
    test_empty_rw;
    test_flush;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
